// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared constants and types for the VDP VRAM scheduler
//
// Holds the default VRAM address width and the per-cycle grant encoding used
// by the scheduler and its CPU port.

package vdp_pkg;

  localparam int VRAM_ADDR_W = 14;

  // Which requester owns the single BRAM port in the current cycle.
  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_DISP,
    GNT_WR,
    GNT_PF
  } gnt_e;

endpackage

// File: rtl/vdp_cpu_port.sv
// rtl/vdp_cpu_port.sv - CPU side of the VRAM scheduler: address register, write buffer, read-ahead
//
// Ports:
//   pxclk, reset         pixel clock, synchronous active-high reset
//   cpu_addr_load/_rd    load addr_reg from cpu_addr; _rd requests a prefetch
//   cpu_wr, cpu_wdata    buffer one write at addr_reg
//   cpu_rd               latch consumed, fetch the next byte
//   wr_gnt, pf_gnt       the scheduler granted the pending write / prefetch
//   vram_rdata           BRAM read data (one cycle after the address)
//   addr_reg, wr_data    current address and buffered write data
//   wr_pend, pf_pend     pending write / pending prefetch
//   rd_latch, overrun    read-ahead byte, sticky overrun flag
//   busy                 any CPU operation pending or in flight

import vdp_pkg::*;

module vdp_cpu_port #(
  parameter int ADDR_WIDTH = VRAM_ADDR_W
) (
  input  logic                  pxclk,
  input  logic                  reset,
  input  logic                  cpu_addr_load,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_addr_rd,
  input  logic                  cpu_wr,
  input  logic [7:0]            cpu_wdata,
  input  logic                  cpu_rd,
  input  logic                  wr_gnt,
  input  logic                  pf_gnt,
  input  logic [7:0]            vram_rdata,
  output logic [ADDR_WIDTH-1:0] addr_reg,
  output logic [7:0]            wr_data,
  output logic                  wr_pend,
  output logic                  pf_pend,
  output logic [7:0]            rd_latch,
  output logic                  overrun,
  output logic                  busy
);

  // Prefetch issued last cycle; its data is on vram_rdata this cycle.
  logic cap;

  assign busy = wr_pend | pf_pend | cap;

  always_ff @(posedge pxclk) begin
    if (reset) begin
      addr_reg <= '0;
      wr_data  <= '0;
      wr_pend  <= 1'b0;
      pf_pend  <= 1'b0;
      cap      <= 1'b0;
      rd_latch <= '0;
      overrun  <= 1'b0;
    end else begin
      // A new address invalidates whatever was being read for the old one.
      if (cap && !cpu_addr_load) begin
        rd_latch <= vram_rdata;
      end
      cap <= pf_gnt;

      if (wr_gnt) begin
        rd_latch <= wr_data;
        addr_reg <= addr_reg + ADDR_WIDTH'(1);
        wr_pend  <= 1'b0;
      end

      if (pf_gnt) begin
        addr_reg <= addr_reg + ADDR_WIDTH'(1);
        pf_pend  <= 1'b0;
      end

      // While busy the buffer is occupied, so new requests are lost, not queued.
      if (cpu_wr) begin
        if (busy) begin
          overrun <= 1'b1;
        end else begin
          wr_data <= cpu_wdata;
          wr_pend <= 1'b1;
        end
      end

      if (cpu_rd) begin
        if (busy) begin
          overrun <= 1'b1;
        end else begin
          pf_pend <= 1'b1;
        end
      end

      // Loading the address restarts the CPU port from a clean state. The
      // scheduler never grants a write/prefetch in a load cycle, so no
      // increment races with this assignment.
      if (cpu_addr_load) begin
        addr_reg <= cpu_addr;
        wr_pend  <= 1'b0;
        pf_pend  <= cpu_addr_rd;
        overrun  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vdp_vram_sched.sv
// rtl/vdp_vram_sched.sv - single-port VRAM scheduler: display fetch over CPU write/prefetch
//
// Ports:
//   pxclk, reset                  pixel clock, synchronous active-high reset
//   disp_req, disp_addr           display fetch request (always wins the port)
//   disp_valid, disp_rdata        display data, one cycle after a granted request
//   cpu_addr_load, cpu_addr,      load the CPU address register, optionally
//   cpu_addr_rd                   scheduling a read-ahead
//   cpu_wr, cpu_wdata             one-deep buffered CPU write
//   cpu_rd                        read-ahead consumed, fetch the next byte
//   cpu_rdata                     read-ahead latch
//   cpu_busy, cpu_overrun         CPU op outstanding, sticky lost-request flag
//   vram_addr, vram_we,           BRAM port, driven combinationally from the
//   vram_wdata, vram_rdata        winner; read data has one cycle latency

import vdp_pkg::*;

module vdp_vram_sched #(
  parameter int ADDR_WIDTH = VRAM_ADDR_W
) (
  input  logic                  pxclk,
  input  logic                  reset,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic                  disp_valid,
  output logic [7:0]            disp_rdata,
  input  logic                  cpu_addr_load,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_addr_rd,
  input  logic                  cpu_wr,
  input  logic [7:0]            cpu_wdata,
  input  logic                  cpu_rd,
  output logic [7:0]            cpu_rdata,
  output logic                  cpu_busy,
  output logic                  cpu_overrun,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic                  vram_we,
  output logic [7:0]            vram_wdata,
  input  logic [7:0]            vram_rdata
);

  gnt_e                  gnt;
  logic                  disp_cap;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [7:0]            wr_data;
  logic                  wr_pend;
  logic                  pf_pend;
  logic [7:0]            rd_latch;
  logic                  overrun;
  logic                  busy;

  // Display first. An address load in the same cycle would collide with the
  // post-increment of a CPU grant, so the load wins and the CPU op waits.
  // Reset forces idle so an interrupted write never reaches the array.
  always_comb begin
    gnt = GNT_IDLE;
    if (reset) begin
      gnt = GNT_IDLE;
    end else if (disp_req) begin
      gnt = GNT_DISP;
    end else if (cpu_addr_load) begin
      gnt = GNT_IDLE;
    end else if (wr_pend) begin
      gnt = GNT_WR;
    end else if (pf_pend) begin
      gnt = GNT_PF;
    end
  end

  assign vram_addr  = (gnt == GNT_DISP) ? disp_addr : addr_reg;
  assign vram_we    = (gnt == GNT_WR);
  assign vram_wdata = wr_data;

  always_ff @(posedge pxclk) begin
    if (reset) begin
      disp_cap <= 1'b0;
    end else begin
      disp_cap <= (gnt == GNT_DISP);
    end
  end

  assign disp_valid  = disp_cap;
  assign disp_rdata  = vram_rdata;
  assign cpu_rdata   = rd_latch;
  assign cpu_busy    = busy;
  assign cpu_overrun = overrun;

  vdp_cpu_port #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cpu_port (
    .pxclk         (pxclk),
    .reset         (reset),
    .cpu_addr_load (cpu_addr_load),
    .cpu_addr      (cpu_addr),
    .cpu_addr_rd   (cpu_addr_rd),
    .cpu_wr        (cpu_wr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rd        (cpu_rd),
    .wr_gnt        (gnt == GNT_WR),
    .pf_gnt        (gnt == GNT_PF),
    .vram_rdata    (vram_rdata),
    .addr_reg      (addr_reg),
    .wr_data       (wr_data),
    .wr_pend       (wr_pend),
    .pf_pend       (pf_pend),
    .rd_latch      (rd_latch),
    .overrun       (overrun),
    .busy          (busy)
  );

endmodule

// File: tb/tb_vdp_vram_sched.sv
// tb/tb_vdp_vram_sched.sv - self-checking bench for vdp_vram_sched

module tb_vdp_vram_sched;

  logic        pxclk = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [13:0] disp_addr;
  logic        disp_valid;
  logic [7:0]  disp_rdata;
  logic        cpu_addr_load;
  logic [13:0] cpu_addr;
  logic        cpu_addr_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd;
  logic [7:0]  cpu_rdata;
  logic        cpu_busy;
  logic        cpu_overrun;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;

  always #5 pxclk = ~pxclk;

  vdp_vram_sched #(.ADDR_WIDTH(14)) dut (
    .pxclk         (pxclk),
    .reset         (reset),
    .disp_req      (disp_req),
    .disp_addr     (disp_addr),
    .disp_valid    (disp_valid),
    .disp_rdata    (disp_rdata),
    .cpu_addr_load (cpu_addr_load),
    .cpu_addr      (cpu_addr),
    .cpu_addr_rd   (cpu_addr_rd),
    .cpu_wr        (cpu_wr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rd        (cpu_rd),
    .cpu_rdata     (cpu_rdata),
    .cpu_busy      (cpu_busy),
    .cpu_overrun   (cpu_overrun),
    .vram_addr     (vram_addr),
    .vram_we       (vram_we),
    .vram_wdata    (vram_wdata),
    .vram_rdata    (vram_rdata)
  );

  // BRAM model: read-first, one cycle latency.
  logic [7:0] mem [0:16383] = '{default: 8'h00};
  always @(posedge pxclk) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  int n_checks = 0;
  int n_err    = 0;
  bit rnd_disp = 1'b0;
  logic        prev_req;
  logic [13:0] prev_addr;
  logic [13:0] dtab [5] = '{14'h0100, 14'h0101, 14'h2000, 14'h2001, 14'h2002};
  logic [7:0]  sh [0:511] = '{default: 8'h00};

  // Display reads only target bytes whose content is fixed once written.
  function automatic logic [7:0] disp_exp(input logic [13:0] a);
    case (a)
      14'h0100: return 8'hA5;
      14'h0101: return 8'h5A;
      14'h2000: return 8'h11;
      14'h2001: return 8'h22;
      14'h2002: return 8'h33;
      default:  return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    if (rnd_disp) begin
      disp_req  = 1'($urandom_range(0, 1));
      disp_addr = dtab[$urandom_range(0, 4)];
    end
    @(negedge pxclk);
    if (disp_req && !reset) begin
      chk("disp_no_we", 32'(vram_we), 0);
      chk("disp_addr_mux", 32'(vram_addr), 32'(disp_addr));
    end
    prev_req  = disp_req && !reset;
    prev_addr = disp_addr;
    @(posedge pxclk);
    #1;
    cpu_addr_load = 1'b0;
    cpu_addr_rd   = 1'b0;
    cpu_wr        = 1'b0;
    cpu_rd        = 1'b0;
    #1;
    chk("disp_valid", 32'(disp_valid), 32'(prev_req));
    if (prev_req) chk("disp_rdata", 32'(disp_rdata), 32'(disp_exp(prev_addr)));
  endtask

  task automatic load(input logic [13:0] a, input logic rd);
    cpu_addr_load = 1'b1;
    cpu_addr      = a;
    cpu_addr_rd   = rd;
    step();
  endtask

  task automatic wr(input logic [7:0] d);
    cpu_wr    = 1'b1;
    cpu_wdata = d;
    step();
  endtask

  task automatic rdp();
    cpu_rd = 1'b1;
    step();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (cpu_busy && n < 100) begin
      step();
      n++;
    end
    chk(tag, 32'(cpu_busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ma;
    logic [7:0] exp_l;

    reset = 1'b1; disp_req = 1'b0; disp_addr = '0;
    cpu_addr_load = 1'b0; cpu_addr = '0; cpu_addr_rd = 1'b0;
    cpu_wr = 1'b0; cpu_wdata = '0; cpu_rd = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_disp_valid", 32'(disp_valid), 0);
    chk("rst_busy", 32'(cpu_busy), 0);
    chk("rst_overrun", 32'(cpu_overrun), 0);
    chk("rst_we", 32'(vram_we), 0);
    chk("rst_rdata", 32'(cpu_rdata), 0);

    // Write sequence
    load(14'h0100, 1'b0);
    chk("wseq_busy0", 32'(cpu_busy), 0);
    wr(8'hA5);
    chk("wseq_busy1", 32'(cpu_busy), 1);
    chk("wseq_we", 32'(vram_we), 1);
    chk("wseq_addr", 32'(vram_addr), 32'h0100);
    chk("wseq_wdata", 32'(vram_wdata), 32'hA5);
    step();
    chk("wseq_busy2", 32'(cpu_busy), 0);
    chk("wseq_mem100", 32'(mem[14'h0100]), 32'hA5);
    wr(8'h5A);
    wait_idle("wseq_idle");
    chk("wseq_mem101", 32'(mem[14'h0101]), 32'h5A);
    chk("wseq_addr_reg", 32'(dut.addr_reg), 32'h0102);
    chk("wseq_latch", 32'(cpu_rdata), 32'h5A);

    // Read-ahead
    load(14'h2000, 1'b0);
    wr(8'h11); wait_idle("ra_w1");
    wr(8'h22); wait_idle("ra_w2");
    wr(8'h33); wait_idle("ra_w3");
    load(14'h2000, 1'b1);
    chk("ra_busy", 32'(cpu_busy), 1);
    chk("ra_issue_addr", 32'(vram_addr), 32'h2000);
    chk("ra_issue_we", 32'(vram_we), 0);
    step();
    step();
    chk("ra_first", 32'(cpu_rdata), 32'h11);
    chk("ra_idle", 32'(cpu_busy), 0);
    rdp();
    step();
    step();
    chk("ra_second", 32'(cpu_rdata), 32'h22);

    // Display priority over a pending write
    load(14'h3000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      disp_req  = 1'b1;
      disp_addr = dtab[$urandom_range(0, 4)];
      if (i == 0) begin
        cpu_wr    = 1'b1;
        cpu_wdata = 8'h9C;
      end
      step();
      chk("dp_busy", 32'(cpu_busy), 1);
    end
    disp_req = 1'b0;
    #1;
    chk("dp_free_we", 32'(vram_we), 1);
    chk("dp_free_addr", 32'(vram_addr), 32'h3000);
    step();
    chk("dp_mem", 32'(mem[14'h3000]), 32'h9C);
    chk("dp_idle", 32'(cpu_busy), 0);

    // Address wrap
    load(14'h3FFF, 1'b0);
    wr(8'h77);
    wait_idle("wrap_idle");
    chk("wrap_mem", 32'(mem[14'h3FFF]), 32'h77);
    chk("wrap_addr", 32'(dut.addr_reg), 0);

    // Overrun
    load(14'h0200, 1'b0);
    wr(8'h12);
    wr(8'h34);
    chk("ovr_flag", 32'(cpu_overrun), 1);
    chk("ovr_addr", 32'(dut.addr_reg), 32'h0201);
    chk("ovr_mem", 32'(mem[14'h0200]), 32'h12);
    chk("ovr_latch", 32'(cpu_rdata), 32'h12);
    load(14'h2000, 1'b0);
    chk("ovr_clear", 32'(cpu_overrun), 0);

    // Address load coincident with a prefetch capture
    load(14'h2000, 1'b1);
    step();
    load(14'h2002, 1'b1);
    chk("lc_latch_kept", 32'(cpu_rdata), 32'h12);
    chk("lc_busy", 32'(cpu_busy), 1);
    step();
    step();
    chk("lc_new_data", 32'(cpu_rdata), 32'h33);
    chk("lc_addr", 32'(dut.addr_reg), 32'h2003);

    // Reset during a granted write
    load(14'h0300, 1'b0);
    wr(8'hEE);
    reset = 1'b1;
    #1;
    chk("rmid_we", 32'(vram_we), 0);
    step();
    reset = 1'b0;
    chk("rmid_busy", 32'(cpu_busy), 0);
    chk("rmid_addr", 32'(dut.addr_reg), 0);
    chk("rmid_latch", 32'(cpu_rdata), 0);
    step();
    chk("rmid_mem", 32'(mem[14'h0300]), 0);

    // Random CPU traffic in 0x1000..0x11FF against a transaction-level model
    rnd_disp = 1'b1;
    ma = 0;
    exp_l = 8'h00;
    for (int i = 0; i < 150; i++) begin
      int op;
      int a;
      logic [7:0] d;
      logic rd;
      op = (i == 0 || ma > 'h11F0) ? 0 : int'($urandom_range(0, 2));
      case (op)
        0: begin
          a  = 'h1000 + int'($urandom_range(0, 'h180));
          rd = 1'($urandom_range(0, 1));
          ma = a;
          if (rd) begin
            exp_l = sh[ma - 'h1000];
            ma++;
          end
          load(14'(a), rd);
        end
        1: begin
          d = 8'($urandom);
          sh[ma - 'h1000] = d;
          exp_l = d;
          ma++;
          wr(d);
        end
        default: begin
          exp_l = sh[ma - 'h1000];
          ma++;
          rdp();
        end
      endcase
      wait_idle("rnd_idle");
      chk("rnd_rdata", 32'(cpu_rdata), 32'(exp_l));
      chk("rnd_overrun", 32'(cpu_overrun), 0);
      chk("rnd_addr", 32'(dut.addr_reg), 32'(ma));
    end
    rnd_disp = 1'b0;
    disp_req = 1'b0;
    step();
    step();
    for (int k = 0; k < 512; k++) begin
      chk("rnd_mem", 32'(mem['h1000 + k]), 32'(sh[k]));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
